// File: rtl/rs_gf_pkg.sv
// rs_gf_pkg: GF(2^8) helpers (poly 0x11D) shared by the syndrome, locator and Chien blocks.
package rs_gf_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e);
        logic [7:0] r;
        int em;
        r  = 8'h01;
        em = ((e % 255) + 255) % 255;
        for (int i = 0; i < 255; i++)
            if (i < em) r = gf_xtime(r);
        return r;
    endfunction

    // With a constant k this folds down to a fixed XOR network.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) r = r ^ p;
            p = gf_xtime(p);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_dec_syndrome_bank_if.sv
// rs_dec_syndrome_bank_if: symbol stream in, held syndromes with valid/ack handshake out.
interface rs_dec_syndrome_bank_if #(parameter int NSYN = 4);

    logic              i_frame_sync;
    logic [7:0]        i_data;
    logic              i_data_sync;
    logic              i_syn_ack;
    logic [8*NSYN-1:0] o_syn;
    logic              o_syn_valid;
    logic              o_syn_zero;
    logic              o_overrun;

    modport master (
        output i_frame_sync, i_data, i_data_sync, i_syn_ack,
        input  o_syn, o_syn_valid, o_syn_zero, o_overrun
    );

    modport slave (
        input  i_frame_sync, i_data, i_data_sync, i_syn_ack,
        output o_syn, o_syn_valid, o_syn_zero, o_overrun
    );

endinterface

// File: rtl/rs_syn_cell.sv
// rs_syn_cell: one Horner syndrome accumulator S <= S*alpha^ALPHA_EXP ^ r plus its holding register.
module rs_syn_cell
    import rs_gf_pkg::*;
#(
    parameter int ALPHA_EXP = 0
) (
    input  logic       i_clk,
    input  logic       i_resb,
    input  logic       i_clr,
    input  logic       i_step,
    input  logic       i_last,
    input  logic [7:0] i_data,
    output logic [7:0] o_hold,
    output logic       o_next_zero
);

    localparam logic [7:0] K = gf_alpha_pow(ALPHA_EXP);

    logic [7:0] acc_q, acc_d, hold_q, hold_d, horner;

    always_comb begin
        horner = gf_mul_const(acc_q, K) ^ i_data;
        acc_d  = i_clr ? 8'h00 : i_step ? (i_last ? 8'h00 : horner) : acc_q;
        hold_d = (i_step && i_last) ? horner : hold_q;
    end

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            acc_q  <= 8'h00;
            hold_q <= 8'h00;
        end else begin
            acc_q  <= acc_d;
            hold_q <= hold_d;
        end
    end

    assign o_hold      = hold_q;
    assign o_next_zero = horner == 8'h00;

endmodule

// File: rtl/rs_dec_syndrome_bank.sv
// rs_dec_syndrome_bank: parametrised GF(2^8) RS syndrome generator with double-buffered result,
// valid/ack handshake, all-zero flag and overrun pulse.
module rs_dec_syndrome_bank
    import rs_gf_pkg::*;
#(
    parameter int N         = 32,
    parameter int NSYN      = 4,
    parameter int FCR       = 0,
    parameter int ASYNC_STB = 1
) (
    input logic                 i_clk,
    input logic                 i_resb,
    rs_dec_syndrome_bank_if.slave bus
);

    localparam int CW = $clog2(N);

    logic [1:0]             sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   valid_q, valid_d, zero_q, zero_d, ovr_q, ovr_d;
    logic                   w_rx, step, last, done;
    logic [NSYN-1:0]        nz;
    logic [NSYN-1:0][7:0]   syn;

    // A frame_sync drops any coincident symbol, so step never fires with it.
    always_comb begin
        w_rx    = (ASYNC_STB != 0) ? ^sync_q : bus.i_data_sync;
        step    = w_rx && !bus.i_frame_sync;
        last    = cnt_q == CW'(N - 1);
        done    = step && last;
        cnt_d   = (bus.i_frame_sync || done) ? '0 : step ? cnt_q + CW'(1) : cnt_q;
        valid_d = done || (valid_q && !bus.i_syn_ack);
        zero_d  = done ? &nz : zero_q;
        ovr_d   = done && valid_q && !bus.i_syn_ack;
    end

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.i_data_sync};
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            ovr_q   <= ovr_d;
        end
    end

    for (genvar j = 0; j < NSYN; j++) begin : g_cell
        rs_syn_cell #(.ALPHA_EXP(FCR + j)) u_cell (
            .i_clk       (i_clk),
            .i_resb      (i_resb),
            .i_clr       (bus.i_frame_sync),
            .i_step      (step),
            .i_last      (last),
            .i_data      (bus.i_data),
            .o_hold      (syn[j]),
            .o_next_zero (nz[j])
        );
    end

    assign bus.o_syn       = syn;
    assign bus.o_syn_valid = valid_q;
    assign bus.o_syn_zero  = zero_q;
    assign bus.o_overrun   = ovr_q;

endmodule

// File: tb/tb_rs_dec_syndrome_bank.sv
// tb_rs_dec_syndrome_bank: directed vectors on strobe and toggle variants (N=32) plus an N=255/NSYN=16/FCR=1 instance.
module tb_rs_dec_syndrome_bank;

    logic clk = 1'b0;
    logic resb = 1'b0;
    int checks = 0;
    int errors = 0;
    int ov0 = 0, ov1 = 0, ov2 = 0;

    always #5 clk = ~clk;

    rs_dec_syndrome_bank_if #(.NSYN(4))  b0 ();
    rs_dec_syndrome_bank_if #(.NSYN(4))  b1 ();
    rs_dec_syndrome_bank_if #(.NSYN(16)) b2 ();

    rs_dec_syndrome_bank #(.N(32), .NSYN(4), .FCR(0), .ASYNC_STB(0)) d0 (.i_clk(clk), .i_resb(resb), .bus(b0));
    rs_dec_syndrome_bank #(.N(32), .NSYN(4), .FCR(0), .ASYNC_STB(1)) d1 (.i_clk(clk), .i_resb(resb), .bus(b1));
    rs_dec_syndrome_bank #(.N(255), .NSYN(16), .FCR(1), .ASYNC_STB(0)) d2 (.i_clk(clk), .i_resb(resb), .bus(b2));

    always @(negedge clk) begin
        if (b0.o_overrun === 1'b1) ov0++;
        if (b1.o_overrun === 1'b1) ov1++;
        if (b2.o_overrun === 1'b1) ov2++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_small(input string tag, input logic [31:0] syn, input logic valid, input logic zero);
        chk({tag, ".d0.syn"},   128'(b0.o_syn),       128'(syn));
        chk({tag, ".d0.valid"}, 128'(b0.o_syn_valid), 128'(valid));
        chk({tag, ".d0.zero"},  128'(b0.o_syn_zero),  128'(zero));
        chk({tag, ".d1.syn"},   128'(b1.o_syn),       128'(syn));
        chk({tag, ".d1.valid"}, 128'(b1.o_syn_valid), 128'(valid));
        chk({tag, ".d1.zero"},  128'(b1.o_syn_zero),  128'(zero));
    endtask

    // Small DUTs get the same symbol; the gap covers the toggle synchroniser latency.
    task automatic sym(input logic [7:0] d, input bit big);
        if (big) begin
            b2.i_data = d;
            b2.i_data_sync = 1'b1;
            tick();
            b2.i_data_sync = 1'b0;
        end else begin
            b0.i_data = d;
            b1.i_data = d;
            b0.i_data_sync = 1'b1;
            b1.i_data_sync = ~b1.i_data_sync;
            tick();
            b0.i_data_sync = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic cw(input int n, input int pa, input logic [7:0] va, input int pb, input logic [7:0] vb);
        for (int i = 0; i < n; i++) sym(i == pa ? va : i == pb ? vb : 8'h00, 1'b0);
    endtask

    task automatic ack_small();
        b0.i_syn_ack = 1'b1;
        b1.i_syn_ack = 1'b1;
        tick();
        b0.i_syn_ack = 1'b0;
        b1.i_syn_ack = 1'b0;
    endtask

    initial begin
        {b0.i_frame_sync, b0.i_data, b0.i_data_sync, b0.i_syn_ack} = '0;
        {b1.i_frame_sync, b1.i_data, b1.i_data_sync, b1.i_syn_ack} = '0;
        {b2.i_frame_sync, b2.i_data, b2.i_data_sync, b2.i_syn_ack} = '0;
        repeat (3) tick();
        chk_small("reset", 32'h0, 1'b0, 1'b0);
        chk("reset.d0.ovr", 128'(b0.o_overrun), 128'h0);
        chk("reset.d2.valid", 128'(b2.o_syn_valid), 128'h0);
        chk("reset.d2.syn", b2.o_syn, 128'h0);
        resb = 1'b1;
        tick();
        // all-zero codeword, with latency check on the final symbol
        cw(31, -1, 8'h00, -1, 8'h00);
        b0.i_data = 8'h00;
        b1.i_data = 8'h00;
        b0.i_data_sync = 1'b1;
        b1.i_data_sync = ~b1.i_data_sync;
        tick();
        b0.i_data_sync = 1'b0;
        chk("lat.d0.valid", 128'(b0.o_syn_valid), 128'h1);
        chk("lat.d1.valid", 128'(b1.o_syn_valid), 128'h0);
        repeat (3) tick();
        chk_small("zero", 32'h0, 1'b1, 1'b1);
        ack_small();
        chk_small("zero_ack", 32'h0, 1'b0, 1'b1);
        cw(32, 30, 8'h05, -1, 8'h00);
        chk_small("s30", 32'h28140A05, 1'b1, 1'b0);
        ack_small();
        chk_small("s30_ack", 32'h28140A05, 1'b0, 1'b0);
        cw(32, 31, 8'h01, -1, 8'h00);
        chk_small("s31", 32'h01010101, 1'b1, 1'b0);
        chk("s31.d0.ov", 128'(ov0), 128'h0);
        chk("s31.d1.ov", 128'(ov1), 128'h0);
        // second result with no ack in between
        cw(32, 30, 8'h05, -1, 8'h00);
        chk("ovr.d0.ov", 128'(ov0), 128'h1);
        chk("ovr.d1.ov", 128'(ov1), 128'h1);
        chk_small("ovr", 32'h28140A05, 1'b1, 1'b0);
        // ack coinciding with completion: no overrun, new data stays valid
        cw(31, 30, 8'h01, -1, 8'h00);
        b0.i_data = 8'h01;
        b1.i_data = 8'h01;
        b0.i_data_sync = 1'b1;
        b1.i_data_sync = ~b1.i_data_sync;
        b0.i_syn_ack = 1'b1;
        b1.i_syn_ack = 1'b1;
        tick();
        b0.i_data_sync = 1'b0;
        b0.i_syn_ack = 1'b0;
        b1.i_syn_ack = 1'b0;
        repeat (3) tick();
        chk_small("ackdone", 32'h09050300, 1'b1, 1'b0);
        chk("ackdone.d0.ov", 128'(ov0), 128'h1);
        chk("ackdone.d1.ov", 128'(ov1), 128'h1);
        ack_small();
        chk_small("ackdone_ack", 32'h09050300, 1'b0, 1'b0);
        // frame_sync after a partial codeword
        for (int i = 0; i < 10; i++) sym(8'hAA, 1'b0);
        b0.i_frame_sync = 1'b1;
        b1.i_frame_sync = 1'b1;
        tick();
        b0.i_frame_sync = 1'b0;
        b1.i_frame_sync = 1'b0;
        chk_small("fs_hold", 32'h09050300, 1'b0, 1'b0);
        cw(32, 30, 8'h05, -1, 8'h00);
        chk_small("fs", 32'h28140A05, 1'b1, 1'b0);
        ack_small();
        // reset mid-codeword
        for (int i = 0; i < 17; i++) sym(8'h33, 1'b0);
        resb = 1'b0;
        b1.i_data_sync = 1'b0;
        tick();
        chk_small("rst_mid", 32'h0, 1'b0, 1'b0);
        chk("rst_mid.d1.ovr", 128'(b1.o_overrun), 128'h0);
        resb = 1'b1;
        tick();
        cw(32, 31, 8'h01, -1, 8'h00);
        chk_small("rst_after", 32'h01010101, 1'b1, 1'b0);
        ack_small();
        // N=255, NSYN=16, FCR=1
        for (int i = 0; i < 255; i++) sym(i == 254 ? 8'h01 : 8'h00, 1'b1);
        chk("big254.syn", b2.o_syn, {16{8'h01}});
        chk("big254.valid", 128'(b2.o_syn_valid), 128'h1);
        chk("big254.zero", 128'(b2.o_syn_zero), 128'h0);
        b2.i_syn_ack = 1'b1;
        tick();
        b2.i_syn_ack = 1'b0;
        chk("big254.ack", 128'(b2.o_syn_valid), 128'h0);
        for (int i = 0; i < 255; i++) sym(i == 253 ? 8'h01 : 8'h00, 1'b1);
        chk("big253.syn", b2.o_syn, 128'h4C261387CDE8743A1D80402010080402);
        chk("big253.valid", 128'(b2.o_syn_valid), 128'h1);
        chk("big.ov", 128'(ov2), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
